// File: rtl/rr_register_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_register_arbiter_pkg
//   Shared definitions for the round-robin register arbiter:
//     state_t   : holding-register occupancy (EMPTY / FULL)
//     calc_idw  : grant-index width, max(1, clog2(n))
// ---------------------------------------------------------------------------
package rr_register_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // An index needs at least one bit even when clog2 would give zero.
  function automatic int calc_idw(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_register_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_register_arbiter_if
//   Bundles the N requester ports and the single downstream port.
//     req_valid [N]        : requester i offers a word
//     req_data  [N*WIDTH]  : requester i's word at [i*WIDTH +: WIDTH]
//     req_ready [N]        : one-hot/zero accept
//     out_valid            : holding register occupied
//     out_data  [WIDTH]    : held word
//     out_id    [IDW]      : index of the requester that supplied out_data
//     out_ready            : downstream consumes the held word
//   Modports:
//     slave  : the arbiter's view
//     master : the producers'/consumer's view (bench side)
// ---------------------------------------------------------------------------
interface rr_register_arbiter_if
  import rr_register_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = calc_idw(N);

  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [IDW-1:0]     out_id;
  logic               out_ready;

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output out_valid,
    output out_data,
    output out_id,
    input  out_ready
  );

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_id,
    output out_ready
  );

endinterface

// File: rtl/rr_register_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational cyclic find-first: returns the first set request at or
//   after i_ptr, searching i_ptr, i_ptr+1, ..., N-1, 0, ..., i_ptr-1.
//   Ports:
//     i_req [N]   : request vector
//     i_ptr [IDW] : search start (always < N)
//     o_any       : at least one request set
//     o_idx [IDW] : winning index (meaningful only when o_any)
// ---------------------------------------------------------------------------
module rr_pick
  import rr_register_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = calc_idw(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic           o_any,
  output logic [IDW-1:0] o_idx
);

  localparam logic [IDW:0] LP_N = (IDW+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IDW-1:0] w_off;
  logic [IDW:0]   w_sum;

  // Doubling the vector lets a plain window starting at i_ptr act as a
  // rotation, so bit k of w_rot is request (i_ptr + k) mod N.
  assign w_dbl = {i_req, i_req};

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IDW:0] w_pos;
    assign w_pos     = {1'b0, i_ptr} + (IDW+1)'(gi);
    assign w_rot[gi] = w_dbl[w_pos];
  end

  assign o_any = |w_rot;

  always_comb begin
    w_off = '0;
    // Descending scan: the lowest set offset is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IDW'(i);
      end
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= LP_N) begin
      o_idx = IDW'(w_sum - LP_N);
    end else begin
      o_idx = IDW'(w_sum);
    end
  end

endmodule

// File: rtl/rr_register_arbiter.sv
// ---------------------------------------------------------------------------
// rr_register_arbiter
//   Round-robin arbiter sharing one 1-deep holding register among N
//   requesters. A word accepted in cycle t is presented in cycle t+1; with
//   out_ready held high one word per cycle flows through.
//   Ports:
//     CLK          : clock, rising edge
//     ASYNCRESETN  : asynchronous active-low reset
//     bus (slave)  : requester handshakes and downstream handshake
//   Parameters:
//     N     : number of requesters (2..16)
//     WIDTH : data word width
// ---------------------------------------------------------------------------
module rr_register_arbiter
  import rr_register_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  rr_register_arbiter_if.slave bus
);

  localparam int             IDW     = calc_idw(N);
  localparam logic [IDW-1:0] LP_LAST = IDW'(N - 1);

  state_t         r_state, w_state_next;
  logic [IDW-1:0] r_ptr, w_ptr_next;
  logic [IDW-1:0] r_id, w_id_next;
  logic [WIDTH-1:0] r_data, w_data_next;

  logic             w_any;
  logic [IDW-1:0]   w_idx;
  logic             w_free;
  logic             w_grant;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_words [N];

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  // The slot is free when empty, or when full and being drained this cycle,
  // which is what lets consume and reload share one edge.
  assign w_free  = (r_state == EMPTY) || bus.out_ready;
  // Gating with the reset keeps req_ready low for the whole reset window,
  // not just from the first clock edge onward.
  assign w_grant = ASYNCRESETN && w_free && w_any;

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    localparam logic [IDW-1:0] LP_IDX = IDW'(gi);
    assign bus.req_ready[gi] = w_grant && (w_idx == LP_IDX);
    assign w_words[gi]       = bus.req_data[gi*WIDTH +: WIDTH];
  end

  // Data only ever reaches the register's D input, never an output.
  assign w_sel_data = w_words[w_idx];

  // -------------------------------------------------------------------------
  // FSM: next state and holding-register load
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_data_next  = r_data;
    w_id_next    = r_id;

    unique case (r_state)
      EMPTY: begin
        if (w_grant) begin
          w_state_next = FULL;
        end
      end
      FULL: begin
        if (w_grant) begin
          w_state_next = FULL;
        end else if (bus.out_ready) begin
          w_state_next = EMPTY;
        end
      end
      default: w_state_next = EMPTY;
    endcase

    // 2:1 mux in front of the holding register: new word or hold.
    if (w_grant) begin
      w_data_next = w_sel_data;
      w_id_next   = w_idx;
      w_ptr_next  = (w_idx == LP_LAST) ? '0 : w_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_data  <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_data  <= w_data_next;
      r_id    <= w_id_next;
    end
  end

  // -------------------------------------------------------------------------
  // Downstream outputs: straight from registers
  // -------------------------------------------------------------------------
  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_data;
  assign bus.out_id    = r_id;

endmodule

// File: tb/tb_rr_register_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_register_arbiter
//   Drives requesters and the downstream port, predicts grants from a
//   cyclic-search model, queues expected words and checks them as the DUT
//   presents them.
// ---------------------------------------------------------------------------
module tb_rr_register_arbiter;
  import rr_register_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = calc_idw(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_register_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

  rr_register_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .CLK         (clk),
    .ASYNCRESETN (rst_n),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             sb_q[$];
  int               m_ptr = 0;
  logic [WIDTH-1:0] d [N];
  logic [N-1:0]     pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // First valid requester at or after the pointer, cyclically; -1 if none.
  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic ordy);
    logic [N*WIDTH-1:0] pk;
    pk = '0;
    for (int i = 0; i < N; i++) pk[i*WIDTH +: WIDTH] = d[i];
    bus.req_valid = v;
    bus.req_data  = pk;
    bus.out_ready = ordy;
  endtask

  // One cycle: drive just after the edge, predict/check mid-cycle.
  task automatic step(input logic [N-1:0] v, input logic ordy, output int g);
    logic [N-1:0] exp_rdy;
    @(posedge clk);
    #1;
    drive(v, ordy);
    @(negedge clk);
    #1;
    // The monitor has already retired a consumed word at this negedge,
    // so an empty queue means the slot is free.
    g = (sb_q.size() == 0) ? model_pick(v) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (g >= 0) begin
      exp_t e;
      e.id   = g;
      e.data = d[g];
      sb_q.push_back(e);
      m_ptr = (g + 1) % N;
    end
  endtask

  // Monitor: compares presented output with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        chk("out_data", 32'(bus.out_data), 32'(sb_q[0].data));
        chk("out_id", 32'(bus.out_id), 32'(sb_q[0].id));
        if (bus.out_valid && bus.out_ready) begin
          $display("xfer id=%0d data=%02h", bus.out_id, bus.out_data);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    for (int i = 0; i < N; i++) d[i] = WIDTH'($urandom);
    pend = '0;

    // Reset with everything asserted: outputs must stay quiet across edges.
    drive('1, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_id", 32'(bus.out_id), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 2 with A5, then a full round to confirm ptr moved to 3.
    d[2] = 8'hA5;
    step(4'b0100, 1'b1, g);
    step(4'b0000, 1'b1, g);
    step(4'b1111, 1'b1, g);
    step(4'b0000, 1'b1, g);

    // Round robin with all requesters valid and downstream always ready.
    repeat (6) begin
      step(4'b1111, 1'b1, g);
      if (g >= 0) d[g] = WIDTH'($urandom);
    end

    // Backpressure for three cycles, then release.
    repeat (3) step(4'b1111, 1'b0, g);
    step(4'b1111, 1'b1, g);
    if (g >= 0) d[g] = WIDTH'($urandom);
    step(4'b0000, 1'b1, g);

    // Wrap and skip: move ptr to 3, then requests 0 and 1 only.
    step(4'b0100, 1'b1, g);
    step(4'b0011, 1'b1, g);
    step(4'b0011, 1'b1, g);
    // Drain.
    step(4'b0000, 1'b1, g);
    step(4'b0000, 1'b1, g);

    // Randomized traffic with occasional withdrawal.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(2) == 0) begin
            pend[i] = 1'b1;
            d[i]    = WIDTH'($urandom);
          end
        end else if ($urandom_range(19) == 0) begin
          pend[i] = 1'b0;
        end
      end
      step(pend, ($urandom_range(3) != 0), g);
      if (g >= 0) pend[g] = 1'b0;
    end

    // Reset while full: out_valid must fall without a clock edge.
    step(4'b1111, 1'b0, g);
    step(4'b1111, 1'b0, g);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    sb_q.delete();
    m_ptr = 0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (5) begin
      step(4'b1010, 1'b1, g);
      if (g >= 0) d[g] = WIDTH'($urandom);
    end
    step(4'b0000, 1'b1, g);
    step(4'b0000, 1'b1, g);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
